// File: rtl/vector_player.sv
// -----------------------------------------------------------------------------
// vector_player
//   Walks a vector display list held in a synchronous frame RAM and drives X/Y
//   DAC codes plus a beam enable. A frame starts on a draw_frame pulse and
//   reads words from FRAME_MIN upward until an END word or until FRAME_MAX has
//   been consumed.
//     MOVE : jump to (x,y) with the beam blanked, then dwell SETTLE clocks.
//     DRAW : trace a Bresenham line from the current point to (x,y), one
//            point every STEP_CYCLES clocks; the beam is lit on each new
//            point (the start point itself is not re-lit).
//     END  : stop and return to IDLE.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   draw_frame  in   1-cycle start pulse (ignored unless IDLE)
//   adrREAD     out  RAM read address
//   dataREAD    in   RAM read data, valid one clock after adrREAD
//   x_out       out  X DAC code
//   y_out       out  Y DAC code
//   beam_on     out  1 = beam lit
//   frame_done  out  high while IDLE (ready for the next frame)
//
// Word format: {cmd[1:0], x[OUT_WIDTH-1:0], y[OUT_WIDTH-1:0]}
//   cmd 00 = MOVE, 01 = DRAW, 1x = END
// -----------------------------------------------------------------------------
module vector_player #(
  parameter int ADR_WIDTH   = 10,
  parameter int DATAWIDTH   = 18,
  parameter int OUT_WIDTH   = 8,
  parameter int FRAME_MIN   = 0,
  parameter int FRAME_MAX   = 1023,
  parameter int STEP_CYCLES = 4,
  parameter int SETTLE      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 draw_frame,
  output logic [ADR_WIDTH-1:0] adrREAD,
  input  logic [DATAWIDTH-1:0] dataREAD,
  output logic [OUT_WIDTH-1:0] x_out,
  output logic [OUT_WIDTH-1:0] y_out,
  output logic                 beam_on,
  output logic                 frame_done
);

  localparam int CNT_MAX = (SETTLE > STEP_CYCLES) ? SETTLE : STEP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Error term: dx/dy are at most 2^OUT_WIDTH-1, err stays within [-dy, dx].
  localparam int ERR_W   = OUT_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_MOVE_S,
    S_LINE,
    S_NEXT
  } state_t;

  state_t                   state_q, state_d;
  logic [ADR_WIDTH-1:0]     adr_q, adr_d;
  logic [OUT_WIDTH-1:0]     x_q, x_d;
  logic [OUT_WIDTH-1:0]     y_q, y_d;
  logic                     beam_q, beam_d;
  logic                     done_q, done_d;
  logic [DATAWIDTH-1:0]     word_q, word_d;
  logic signed [ERR_W-1:0]  dx_q, dx_d;
  logic signed [ERR_W-1:0]  dy_q, dy_d;
  logic signed [ERR_W-1:0]  err_q, err_d;
  logic                     sx_q, sx_d;   // 1 = step towards smaller x
  logic                     sy_q, sy_d;   // 1 = step towards smaller y
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  // Fields of the latched word
  logic [1:0]               w_cmd;
  logic [OUT_WIDTH-1:0]     w_x;
  logic [OUT_WIDTH-1:0]     w_y;

  // Line set-up and step helpers
  logic signed [ERR_W-1:0]  diff_x;
  logic signed [ERR_W-1:0]  diff_y;
  logic signed [ERR_W-1:0]  abs_x;
  logic signed [ERR_W-1:0]  abs_y;
  logic signed [ERR_W:0]    e2;
  logic signed [ERR_W:0]    dx_e;
  logic signed [ERR_W:0]    dy_e;
  logic [OUT_WIDTH-1:0]     x_step;
  logic [OUT_WIDTH-1:0]     y_step;

  assign w_cmd = word_q[DATAWIDTH-1 -: 2];
  assign w_x   = word_q[2*OUT_WIDTH-1 -: OUT_WIDTH];
  assign w_y   = word_q[OUT_WIDTH-1:0];

  always_comb begin
    diff_x = $signed({2'b00, w_x}) - $signed({2'b00, x_q});
    diff_y = $signed({2'b00, w_y}) - $signed({2'b00, y_q});
    abs_x  = diff_x[ERR_W-1] ? -diff_x : diff_x;
    abs_y  = diff_y[ERR_W-1] ? -diff_y : diff_y;
    // One extra bit so 2*err and -dy never wrap in the comparisons.
    e2     = {err_q, 1'b0};
    dx_e   = {dx_q[ERR_W-1], dx_q};
    dy_e   = {dy_q[ERR_W-1], dy_q};
    x_step = sx_q ? (x_q - OUT_WIDTH'(1)) : (x_q + OUT_WIDTH'(1));
    y_step = sy_q ? (y_q - OUT_WIDTH'(1)) : (y_q + OUT_WIDTH'(1));
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    x_d     = x_q;
    y_d     = y_q;
    beam_d  = beam_q;
    done_d  = done_q;
    word_d  = word_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        beam_d = 1'b0;
        done_d = 1'b1;
        if (draw_frame) begin
          adr_d   = ADR_WIDTH'(FRAME_MIN);
          done_d  = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: state_d = S_WAIT;

      S_WAIT: begin
        word_d  = dataREAD;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (w_cmd[1]) begin
          beam_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!w_cmd[0]) begin
          x_d     = w_x;
          y_d     = w_y;
          beam_d  = 1'b0;
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = S_MOVE_S;
        end else begin
          dx_d    = abs_x;
          dy_d    = abs_y;
          sx_d    = diff_x[ERR_W-1];
          sy_d    = diff_y[ERR_W-1];
          err_d   = abs_x - abs_y;
          cnt_d   = CNT_W'(STEP_CYCLES - 1);
          state_d = S_LINE;
        end
      end

      S_MOVE_S: begin
        if (cnt_q == '0) begin
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_LINE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if ((x_q == w_x) && (y_q == w_y)) begin
          // Target reached (also covers a zero-length DRAW): blank and move on.
          beam_d  = 1'b0;
          state_d = S_NEXT;
        end else begin
          // Both tests use the pre-update e2; err may take both corrections.
          beam_d = 1'b1;
          cnt_d  = CNT_W'(STEP_CYCLES - 1);
          if ((e2 > -dy_e) && (e2 < dx_e)) begin
            err_d = err_q - dy_q + dx_q;
            x_d   = x_step;
            y_d   = y_step;
          end else if (e2 > -dy_e) begin
            err_d = err_q - dy_q;
            x_d   = x_step;
          end else if (e2 < dx_e) begin
            err_d = err_q + dx_q;
            y_d   = y_step;
          end
        end
      end

      S_NEXT: begin
        if (adr_q == ADR_WIDTH'(FRAME_MAX)) begin
          beam_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          adr_d   = adr_q + ADR_WIDTH'(1);
          state_d = S_FETCH;
        end
      end

      default: begin
        beam_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      adr_q   <= ADR_WIDTH'(FRAME_MIN);
      x_q     <= '0;
      y_q     <= '0;
      beam_q  <= 1'b0;
      done_q  <= 1'b1;
      word_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      beam_q  <= beam_d;
      done_q  <= done_d;
      word_q  <= word_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign adrREAD    = adr_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign beam_on    = beam_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_vector_player.sv
// -----------------------------------------------------------------------------
// tb_vector_player
//   Directed frames against vector_player with a behavioural synchronous RAM.
//   Each change of {frame_done, beam_on, x_out, y_out} is an output event; the
//   stimulus side queues the hand-computed event sequence (with how many
//   clocks each event must persist, 0 = not checked) and a monitor compares.
// -----------------------------------------------------------------------------
module tb_vector_player;

  localparam int AW = 10;
  localparam int DW = 18;
  localparam int OW = 8;

  logic          clk;
  logic          rst;
  logic          draw_frame;
  logic [AW-1:0] adrREAD;
  logic [DW-1:0] dataREAD;
  logic [OW-1:0] x_out;
  logic [OW-1:0] y_out;
  logic          beam_on;
  logic          frame_done;

  vector_player #(
    .ADR_WIDTH  (AW),
    .DATAWIDTH  (DW),
    .OUT_WIDTH  (OW),
    .FRAME_MIN  (0),
    .FRAME_MAX  (3),
    .STEP_CYCLES(4),
    .SETTLE     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .draw_frame(draw_frame),
    .adrREAD   (adrREAD),
    .dataREAD  (dataREAD),
    .x_out     (x_out),
    .y_out     (y_out),
    .beam_on   (beam_on),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous frame RAM
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) dataREAD <= mem[adrREAD];

  int n_cmp  = 0;
  int n_fail = 0;
  int max_adr = 0;

  // Scoreboard: {done, beam, x, y} and required persistence in clocks
  logic [17:0] exp_q [$];
  int          dur_q [$];
  logic [17:0] cur;
  int          cur_dur;
  int          pend_dur;
  int          ev_n;
  bit          mon_en = 1'b0;

  function automatic logic [DW-1:0] w(input logic [1:0] c, input int x, input int y);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = x[7:0];
    yb = y[7:0];
    return {c, xb, yb};
  endfunction

  task automatic push(input int d, input int b, input int x, input int y, input int dur);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = x[7:0];
    yb = y[7:0];
    exp_q.push_back({d[0], b[0], xb, yb});
    dur_q.push_back(dur);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = w(2'b10, 0, 0);
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1 draw_frame = 1'b1;
    @(posedge clk);
    #1 draw_frame = 1'b0;
    chk("frame_done_low_after_start", int'(frame_done), 0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < budget) begin
      @(posedge clk);
      #1 k++;
    end
    chk({name, "_completes"}, int'(frame_done === 1'b1), 1);
  endtask

  task automatic wait_beam(input int budget);
    int k;
    k = 0;
    while (beam_on !== 1'b1 && k < budget) begin
      @(posedge clk);
      #1 k++;
    end
    chk("beam_lights_before_abort", int'(beam_on === 1'b1), 1);
  endtask

  // Monitor: one comparison per output event, plus a duration check of the
  // event that just ended when its persistence was specified.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [17:0] now;
      logic [17:0] e;
      int          d;
      now = {frame_done, beam_on, x_out, y_out};
      max_adr = (int'(adrREAD) > max_adr) ? int'(adrREAD) : max_adr;
      if (now !== cur) begin
        if (pend_dur != 0) begin
          n_cmp++;
          if (cur_dur != pend_dur) begin
            n_fail++;
            $display("FAIL event_duration x=%0d y=%0d beam=%0d: got %0d clks expected %0d",
                     cur[15:8], cur[7:0], cur[16], cur_dur, pend_dur);
          end
        end
        n_cmp++;
        ev_n++;
        if (exp_q.size() == 0) begin
          n_fail++;
          pend_dur = 0;
          $display("FAIL unexpected_event: got done=%0d beam=%0d x=%0d y=%0d expected none",
                   now[17], now[16], now[15:8], now[7:0]);
        end else begin
          e = exp_q.pop_front();
          d = dur_q.pop_front();
          pend_dur = d;
          if (now !== e) begin
            n_fail++;
            $display("FAIL event_value: got done=%0d beam=%0d x=%0d y=%0d expected done=%0d beam=%0d x=%0d y=%0d",
                     now[17], now[16], now[15:8], now[7:0], e[17], e[16], e[15:8], e[7:0]);
          end else begin
            $display("event %0d: done=%0d beam=%0d x=%0d y=%0d", ev_n,
                     now[17], now[16], now[15:8], now[7:0]);
          end
        end
        cur     = now;
        cur_dur = 1;
      end else begin
        cur_dur++;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    draw_frame = 1'b0;
    ev_n       = 0;
    clear_mem();

    // 1. Reset values and idle without a start pulse
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", int'(x_out), 0);
    chk("reset_y", int'(y_out), 0);
    chk("reset_beam", int'(beam_on), 0);
    chk("reset_done", int'(frame_done), 1);
    chk("reset_adr", int'(adrREAD), 0);
    rst      = 1'b0;
    cur      = {1'b1, 1'b0, 8'd0, 8'd0};
    cur_dur  = 0;
    pend_dur = 0;
    mon_en   = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_done_no_start", int'(frame_done), 1);
    chk("idle_adr_no_start", int'(adrREAD), 0);

    // 2. MOVE(10,20), DRAW(14,20), END
    mem[0] = w(2'b00, 10, 20);
    mem[1] = w(2'b01, 14, 20);
    mem[2] = w(2'b10, 0, 0);
    push(0, 0, 0, 0, 3);
    push(0, 0, 10, 20, 24);
    for (int x = 11; x <= 14; x++) push(0, 1, x, 20, 4);
    push(0, 0, 14, 20, 4);
    push(1, 0, 14, 20, 0);
    start_frame();
    wait_done("horizontal_line", 3000);

    // 3. MOVE(0,0), DRAW(3,1), END
    mem[0] = w(2'b00, 0, 0);
    mem[1] = w(2'b01, 3, 1);
    mem[2] = w(2'b10, 0, 0);
    push(0, 0, 14, 20, 3);
    push(0, 0, 0, 0, 24);
    push(0, 1, 1, 0, 4);
    push(0, 1, 2, 1, 4);
    push(0, 1, 3, 1, 4);
    push(0, 0, 3, 1, 4);
    push(1, 0, 3, 1, 0);
    start_frame();
    wait_done("shallow_line", 3000);

    // 5a. draw_frame pulsed mid-line is ignored
    mem[0] = w(2'b00, 10, 20);
    mem[1] = w(2'b01, 14, 20);
    mem[2] = w(2'b10, 0, 0);
    push(0, 0, 3, 1, 3);
    push(0, 0, 10, 20, 24);
    for (int x = 11; x <= 14; x++) push(0, 1, x, 20, 4);
    push(0, 0, 14, 20, 4);
    push(1, 0, 14, 20, 0);
    start_frame();
    wait_beam(3000);
    @(posedge clk);
    #1 draw_frame = 1'b1;
    @(posedge clk);
    #1 draw_frame = 1'b0;
    wait_done("restart_ignored", 3000);

    // 5b. rst asserted mid-line, between clock edges
    push(0, 0, 14, 20, 3);
    push(0, 0, 10, 20, 24);
    push(0, 1, 11, 20, 0);
    push(1, 0, 0, 0, 0);
    start_frame();
    wait_beam(3000);
    #6 rst = 1'b1;
    #1;
    chk("async_rst_x", int'(x_out), 0);
    chk("async_rst_y", int'(y_out), 0);
    chk("async_rst_beam", int'(beam_on), 0);
    chk("async_rst_done", int'(frame_done), 1);
    chk("async_rst_adr", int'(adrREAD), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_stays_idle", int'(frame_done), 1);
    chk("post_rst_beam_off", int'(beam_on), 0);

    // 6. zero-length DRAW, END encoded as 11
    mem[0] = w(2'b00, 5, 5);
    mem[1] = w(2'b01, 5, 5);
    mem[2] = w(2'b11, 0, 0);
    push(0, 0, 0, 0, 3);
    push(0, 0, 5, 5, 28);
    push(1, 0, 5, 5, 0);
    start_frame();
    wait_done("zero_length", 3000);

    // 4. full diagonal, no END: list runs out at FRAME_MAX=3
    mem[0] = w(2'b00, 255, 0);
    mem[1] = w(2'b01, 0, 255);
    mem[2] = w(2'b01, 0, 255);
    mem[3] = w(2'b01, 0, 255);
    mem[4] = w(2'b00, 7, 7);
    push(0, 0, 5, 5, 3);
    push(0, 0, 255, 0, 24);
    for (int i = 1; i <= 255; i++) push(0, 1, 255 - i, i, 4);
    push(0, 0, 0, 255, 17);
    push(1, 0, 0, 255, 0);
    start_frame();
    wait_done("diagonal_frame_max", 5000);
    #1;
    chk("frame_max_adr_holds", int'(adrREAD), 3);

    repeat (20) @(posedge clk);
    #1;
    chk("all_events_seen", exp_q.size(), 0);
    chk("max_address_read", max_adr, 3);
    chk("final_x", int'(x_out), 0);
    chk("final_y", int'(y_out), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
